datapath: RTL and testbench

//  32-bit single-bus CPU datapath: 16 GPRs R0..R15, HI, LO, PC, IR, MAR, MDR, Y, 64-bit Z, one ALU.

---
 rtl/datapath.sv | 149 ++++++++++++++
 tb/tb_datapath.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: GPRs, special registers, bus mux and ALU.
// Exactly one source drives the bus each cycle; any enabled register latches it on the clock edge.
module datapath (
   input  logic        clk,
   input  logic        clr,
   input  logic [15:0] R_rd,
   input  logic [15:0] R_wrt,
   input  logic        HI_out,
   input  logic        LO_out,
   input  logic        Zhi_out,
   input  logic        Zlo_out,
   input  logic        PC_out,
   input  logic        MDR_out,
   input  logic        MAR_out,
   input  logic        In_out,
   input  logic        C_out,
   input  logic        MAR_rd,
   input  logic        Zlo_rd,
   input  logic        PC_rd,
   input  logic        MDR_rd,
   input  logic        IR_rd,
   input  logic        Y_rd,
   input  logic        IncPC,
   input  logic        Read,
   input  logic [4:0]  op_sel,
   input  logic        BAout,
   input  logic [31:0] Mdatain,
   output logic [31:0] r0_view,
   output logic [31:0] r5_view,
   output logic [31:0] Y_view,
   output logic [31:0] Zlo_view,
   output logic [31:0] MDR_view,
   output logic [31:0] PC_view,
   output logic [31:0] BusMuxOut,
   output logic [31:0] Data_view
);

   function automatic logic [63:0] sext64(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   logic [31:0] gpr_q [16];
   logic [31:0] gpr_d [16];
   logic [31:0] hi_q, lo_q, pc_q, mar_q, mdr_q, y_q;
   logic [31:0] hi_d, lo_d, pc_d, mar_d, mdr_d, y_d;
   // Only the sign-extended constant field of IR is ever observable.
   logic [18:0] ir_q, ir_d;
   logic [63:0] z_q, z_d;

   logic [31:0] gpr_bus_s, bus_s, mdr_in_s;
   logic [63:0] alu_s, rot_r_s, rot_l_s;
   logic [31:0] shra_s;
   logic [4:0]  sh_s;

   // Bus source mux: lowest-numbered GPR wins, then fixed priority of specials.
   always_comb begin
      gpr_bus_s = 32'h0;
      for (int i = 15; i >= 1; i--) begin
         gpr_bus_s = R_wrt[i] ? gpr_q[i] : gpr_bus_s;
      end
      gpr_bus_s = R_wrt[0] ? (BAout ? gpr_q[0] : 32'h0) : gpr_bus_s;
      if (R_wrt != 16'h0)  bus_s = gpr_bus_s;
      else if (HI_out)     bus_s = hi_q;
      else if (LO_out)     bus_s = lo_q;
      else if (Zhi_out)    bus_s = z_q[63:32];
      else if (Zlo_out)    bus_s = z_q[31:0];
      else if (PC_out)     bus_s = pc_q;
      else if (MDR_out)    bus_s = mdr_q;
      else if (MAR_out)    bus_s = mar_q;
      else if (In_out)     bus_s = 32'h0;
      else if (C_out)      bus_s = {{13{ir_q[18]}}, ir_q};
      else                 bus_s = 32'h0;
   end

   // ALU: A is Y, B is the bus; logic/shift results leave the high word clear.
   always_comb begin
      sh_s    = bus_s[4:0];
      rot_r_s = {y_q, y_q} >> sh_s;
      rot_l_s = {y_q, y_q} << sh_s;
      shra_s  = $unsigned($signed(y_q) >>> sh_s);
      case (op_sel)
         5'b00011: alu_s = sext64(y_q + bus_s);
         5'b00100: alu_s = sext64(y_q - bus_s);
         5'b00101: alu_s = {32'h0, y_q & bus_s};
         5'b00110: alu_s = {32'h0, y_q | bus_s};
         5'b00111: alu_s = {32'h0, y_q >> sh_s};
         5'b01000: alu_s = {32'h0, shra_s};
         5'b01001: alu_s = {32'h0, y_q << sh_s};
         5'b01010: alu_s = {32'h0, rot_r_s[31:0]};
         5'b01011: alu_s = {32'h0, rot_l_s[63:32]};
         5'b10001: alu_s = sext64(32'h0 - bus_s);
         5'b10010: alu_s = {32'h0, ~bus_s};
         default:  alu_s = 64'h0;
      endcase
   end

   // Next-state selection for every register; PC_rd outranks IncPC.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         gpr_d[i] = R_rd[i] ? bus_s : gpr_q[i];
      end
      hi_d     = hi_q;
      lo_d     = lo_q;
      mdr_in_s = Read ? Mdatain : bus_s;
      mdr_d    = MDR_rd ? mdr_in_s : mdr_q;
      mar_d    = MAR_rd ? bus_s : mar_q;
      ir_d     = IR_rd ? bus_s[18:0] : ir_q;
      y_d      = Y_rd ? bus_s : y_q;
      z_d      = Zlo_rd ? alu_s : z_q;
      if (PC_rd)      pc_d = bus_s;
      else if (IncPC) pc_d = pc_q + 32'd1;
      else            pc_d = pc_q;
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < 16; i++) gpr_q[i] <= 32'h0;
         hi_q  <= 32'h0;
         lo_q  <= 32'h0;
         pc_q  <= 32'h0;
         mar_q <= 32'h0;
         mdr_q <= 32'h0;
         y_q   <= 32'h0;
         ir_q  <= 19'h0;
         z_q   <= 64'h0;
      end else begin
         for (int i = 0; i < 16; i++) gpr_q[i] <= gpr_d[i];
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         pc_q  <= pc_d;
         mar_q <= mar_d;
         mdr_q <= mdr_d;
         y_q   <= y_d;
         ir_q  <= ir_d;
         z_q   <= z_d;
      end
   end

   assign r0_view   = gpr_q[0];
   assign r5_view   = gpr_q[5];
   assign Y_view    = y_q;
   assign Zlo_view  = z_q[31:0];
   assign MDR_view  = mdr_q;
   assign PC_view   = pc_q;
   assign BusMuxOut = bus_s;
   assign Data_view = mdr_in_s;

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for the datapath with hand-computed expectations.
module tb_datapath;

   logic        clk = 1'b0;
   logic        clr;
   logic [15:0] R_rd, R_wrt;
   logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
   logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, IncPC, Read, BAout;
   logic [4:0]  op_sel;
   logic [31:0] Mdatain;
   logic [31:0] r0_view, r5_view, Y_view, Zlo_view, MDR_view, PC_view, BusMuxOut, Data_view;

   int n_tests = 0;
   int n_fail  = 0;

   datapath dut (
      .clk(clk), .clr(clr), .R_rd(R_rd), .R_wrt(R_wrt),
      .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
      .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out), .C_out(C_out),
      .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
      .Y_rd(Y_rd), .IncPC(IncPC), .Read(Read), .op_sel(op_sel), .BAout(BAout),
      .Mdatain(Mdatain),
      .r0_view(r0_view), .r5_view(r5_view), .Y_view(Y_view), .Zlo_view(Zlo_view),
      .MDR_view(MDR_view), .PC_view(PC_view), .BusMuxOut(BusMuxOut), .Data_view(Data_view)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      R_rd = 16'h0; R_wrt = 16'h0;
      {HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out} = 9'h0;
      {MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, IncPC, Read, BAout} = 9'h0;
      op_sel = 5'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_mdr(input logic [31:0] v);
      idle(); Mdatain = v; Read = 1'b1; MDR_rd = 1'b1; tick(); idle();
   endtask

   task automatic mdr_to_r(input int i);
      idle(); MDR_out = 1'b1; R_rd[i] = 1'b1; tick(); idle();
   endtask

   // ALU op with R0 (BAout=1) on the bus, or MDR when use_mdr is set.
   task automatic alu_op(input logic [4:0] op, input logic use_mdr);
      idle();
      if (use_mdr) MDR_out = 1'b1;
      else begin BAout = 1'b1; R_wrt[0] = 1'b1; end
      op_sel = op; Zlo_rd = 1'b1; tick(); idle();
   endtask

   initial begin
      idle(); Mdatain = 32'h0; clr = 1'b0;
      #2;
      check("rst_r0", r0_view, 32'h0);
      check("rst_pc", PC_view, 32'h0);
      check("rst_zlo", Zlo_view, 32'h0);
      check("rst_bus", BusMuxOut, 32'h0);
      @(negedge clk); clr = 1'b1;

      load_mdr(32'hFFFF_FFFF);
      check("mdr_load", MDR_view, 32'hFFFF_FFFF);
      mdr_to_r(0);
      check("r0_from_mdr", r0_view, 32'hFFFF_FFFF);

      Mdatain = 32'h1234_5678; Read = 1'b1; #1;
      check("data_view_mem", Data_view, 32'h1234_5678);
      Read = 1'b0; #1;
      check("data_view_bus", Data_view, 32'h0);

      load_mdr(32'h5A5A_5A5A); mdr_to_r(5);
      check("r5_preload", r5_view, 32'h5A5A_5A5A);
      idle(); BAout = 1'b1; R_wrt[0] = 1'b1; #1;
      check("bus_r0_ba1", BusMuxOut, 32'hFFFF_FFFF);
      alu_op(5'b10010, 1'b0);
      check("not_ffff", Zlo_view, 32'h0);
      idle(); Zlo_out = 1'b1; R_rd[5] = 1'b1; tick(); idle();
      check("r5_from_z", r5_view, 32'h0);

      idle(); R_wrt[0] = 1'b1; #1;
      check("bus_r0_ba0", BusMuxOut, 32'h0);
      op_sel = 5'b10010; Zlo_rd = 1'b1; tick(); idle();
      check("not_zero", Zlo_view, 32'hFFFF_FFFF);
      Zhi_out = 1'b1; #1;
      check("not_zhi", BusMuxOut, 32'h0);

      load_mdr(32'd7);
      idle(); MDR_out = 1'b1; PC_rd = 1'b1; IncPC = 1'b1; tick(); idle();
      check("pc_rd_prio", PC_view, 32'd7);
      IncPC = 1'b1; tick(); idle();
      check("pc_inc", PC_view, 32'd8);
      load_mdr(32'hFFFF_FFFF);
      idle(); MDR_out = 1'b1; PC_rd = 1'b1; tick(); idle();
      IncPC = 1'b1; tick(); idle();
      check("pc_wrap", PC_view, 32'h0);

      load_mdr(32'h19); mdr_to_r(5);
      load_mdr(32'd7);  mdr_to_r(0);
      idle(); R_wrt[5] = 1'b1; Y_rd = 1'b1; tick(); idle();
      check("y_load", Y_view, 32'h19);
      alu_op(5'b00011, 1'b0); check("add", Zlo_view, 32'h20);
      alu_op(5'b00100, 1'b0); check("sub", Zlo_view, 32'h12);
      alu_op(5'b00101, 1'b0); check("and", Zlo_view, 32'h1);
      alu_op(5'b00110, 1'b0); check("or", Zlo_view, 32'h1F);
      alu_op(5'b10001, 1'b0); check("neg", Zlo_view, 32'hFFFF_FFF9);
      Zhi_out = 1'b1; #1;
      check("neg_zhi", BusMuxOut, 32'hFFFF_FFFF);

      load_mdr(32'h8000_0000);
      idle(); MDR_out = 1'b1; Y_rd = 1'b1; tick(); idle();
      load_mdr(32'd4);
      alu_op(5'b01000, 1'b1); check("shra", Zlo_view, 32'hF800_0000);
      Zhi_out = 1'b1; #1;
      check("shra_zhi", BusMuxOut, 32'h0);
      alu_op(5'b00111, 1'b1); check("shr", Zlo_view, 32'h0800_0000);
      alu_op(5'b01001, 1'b1); check("shl", Zlo_view, 32'h0);
      alu_op(5'b01011, 1'b1); check("rol", Zlo_view, 32'h0000_0008);
      alu_op(5'b01010, 1'b1); check("ror", Zlo_view, 32'h0800_0000);
      alu_op(5'b00000, 1'b1); check("unlisted", Zlo_view, 32'h0);

      idle(); MDR_out = 1'b1; op_sel = 5'b00011; Y_rd = 1'b1; Zlo_rd = 1'b1; tick(); idle();
      check("same_edge_z", Zlo_view, 32'h8000_0004);
      check("same_edge_y", Y_view, 32'd4);

      idle(); R_wrt[5] = 1'b1; R_rd[5] = 1'b1; tick(); idle();
      check("self_load", r5_view, 32'h19);

      BAout = 1'b1; R_wrt[0] = 1'b1; MDR_out = 1'b1; #1;
      check("bus_prio", BusMuxOut, 32'd7);
      idle(); HI_out = 1'b1; MDR_out = 1'b1; #1;
      check("hi_zero", BusMuxOut, 32'h0);
      idle(); #1;
      check("bus_none", BusMuxOut, 32'h0);

      load_mdr(32'h0004_0000);
      idle(); MDR_out = 1'b1; IR_rd = 1'b1; MAR_rd = 1'b1; tick(); idle();
      C_out = 1'b1; #1;
      check("c_sext", BusMuxOut, 32'hFFFC_0000);
      idle(); MAR_out = 1'b1; #1;
      check("mar_bus", BusMuxOut, 32'h0004_0000);

      idle(); #1; clr = 1'b0; #1;
      check("clr_r0", r0_view, 32'h0);
      check("clr_r5", r5_view, 32'h0);
      check("clr_y", Y_view, 32'h0);
      check("clr_zlo", Zlo_view, 32'h0);
      check("clr_mdr", MDR_view, 32'h0);
      check("clr_pc", PC_view, 32'h0);
      clr = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
